mod_counter_ld: RTL and testbench
=================================

Name: mod_counter_ld

Overview:
- Parametrised, loadable modulo up/down counter; next generation of the team's fixed 4-bit mod-16 loadable counter (init/set/reset/out).
- Adds configurable width and modulus, count enable, direction control, wrap/saturate mode, terminal-count and wrap-event flags.
- Used as a generic event/timing counter beside the control FSMs in the assignment designs.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MAX, 15, terminal value; count range is 0..MAX. Requires MAX <= 2^WIDTH-1.
- WRAP, 1, 1 = wrap at the ends of the range; 0 = saturate at the ends.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset; sampled on rising edge of clk; 0 clears state.
- init  in  WIDTH  load value.
- set  in  1  synchronous load strobe, active-high.
- en  in  1  count enable, active-high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- out  out  WIDTH  registered count value.
- tc  out  1  combinational terminal count: en & ((up & out==MAX) | (~up & out==0)).
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap or saturation hit.

Behaviour:
- Reset: reset==0 at posedge clk -> out=0, wrap=0. Overrides set and en. Deasserting reset mid-count restarts from 0 on the next enabled edge.
- Priority per edge: reset, then set, then en, then hold.
- Load: set==1 -> out = init if init <= MAX, else out = MAX (clamped). wrap=0. Load ignores en and up. Single-cycle latency: value visible the cycle after the edge.
- Count, en==1, set==0, up==1: out<MAX -> out+1. out==MAX -> 0 if WRAP=1, held at MAX if WRAP=0. In both cases wrap=1 next cycle.
- Count, en==1, set==0, up==0: out>0 -> out-1. out==0 -> MAX if WRAP=1, held at 0 if WRAP=0. In both cases wrap=1 next cycle.
- Hold: en==0, set==0 -> out unchanged, wrap=0.
- wrap is high for exactly one cycle per terminal event. It stays high on consecutive cycles while saturated with en==1.
- Direction change takes effect on the same edge; there is no pipeline.
- Out-of-range state: out is only ever written with legal values, so out > MAX is unreachable.
- Arithmetic is WIDTH bits wide. The MAX compare uses a WIDTH-bit constant. Incrementing at 2^WIDTH-1 with MAX == 2^WIDTH-1 follows the WRAP rule, not natural overflow.
- No latches. All state is updated in a single clocked process. tc is the only combinational output.

Optional Feature:
- Macro: MOD_COUNTER_MATCH_EN.
- Defined: adds input match_val [WIDTH] and output match [1]. match is registered and goes high the cycle after out transitions to a value equal to match_val, whether by count or by load. match is 0 during reset and while holding.
- Undefined: neither port exists, no compare logic is built, and the behaviour of all other ports is identical.

Test Plan:
- Reset/load: reset=0 for 2 cycles -> out=0, wrap=0. Release reset, set=1, init=9 -> out=9 next cycle. Then init=20 with WIDTH=5, MAX=15 -> out=15 (clamped).
- Up wrap (WRAP=1, MAX=15): load 14, en=1, up=1 -> out 15 then 0. tc=1 while out=15. wrap=1 in exactly the cycle out=0.
- Down wrap (MAX=9): load 1, en=1, up=0 -> out 0 then 9. tc=1 at out=0. wrap pulse in the cycle out=9.
- Saturate (WRAP=0, MAX=15): load 13, count up 5 cycles -> 14, 15, 15, 15, 15. wrap=1 on the last three cycles.
- Priority/mid-op: while counting at out=7, assert set=1 with init=3 and en=1 -> out=3. Next, assert reset=0 with set=1 -> out=0. Hold en=0 -> out unchanged for 4 cycles.
- MOD_COUNTER_MATCH_EN: match_val=5, load 3, count up -> match=1 only in the cycle after out becomes 5. Load 5 directly -> match=1 next cycle.

Source files
------------

// File: rtl/mod_counter_ld_if.sv
// Bus bundle for mod_counter_ld: load/count controls in, count/flags out.
// Optional compare ports exist only when MOD_COUNTER_MATCH_EN is defined.
interface mod_counter_ld_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_init;
  logic             i_set;
  logic             i_en;
  logic             i_up;
  logic [WIDTH-1:0] o_out;
  logic             o_tc;
  logic             o_wrap;
`ifdef MOD_COUNTER_MATCH_EN
  logic [WIDTH-1:0] i_match_val;
  logic             o_match;

  modport master (output i_init, i_set, i_en, i_up, i_match_val,
                  input  o_out, o_tc, o_wrap, o_match);
  modport slave  (input  i_init, i_set, i_en, i_up, i_match_val,
                  output o_out, o_tc, o_wrap, o_match);
`else
  modport master (output i_init, i_set, i_en, i_up,
                  input  o_out, o_tc, o_wrap);
  modport slave  (input  i_init, i_set, i_en, i_up,
                  output o_out, o_tc, o_wrap);
`endif
endinterface

// File: rtl/mod_counter_ld.sv
// Loadable modulo up/down counter, 0..MAX, wrap or saturate; 1-cycle load/count latency, no backpressure.
// Optional registered match flag against i_match_val when MOD_COUNTER_MATCH_EN is defined.
module mod_counter_ld #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter bit WRAP  = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mod_counter_ld_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_hit;
  logic             w_upd;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_at_max  = (r_out == MAX_V);
    w_at_zero = (r_out == '0);
    w_hit     = bus.i_up ? w_at_max : w_at_zero;
    w_upd     = bus.i_set | bus.i_en;
    w_load    = (bus.i_init > MAX_V) ? MAX_V : bus.i_init;
  end

  // End-of-range handling is explicit so MAX == 2^WIDTH-1 never relies on overflow.
  always_comb begin
    w_step = r_out;
    if (bus.i_up) begin
      if (!w_at_max)  w_step = r_out + WIDTH'(1);
      else if (WRAP)  w_step = '0;
      else            w_step = MAX_V;
    end else begin
      if (!w_at_zero) w_step = r_out - WIDTH'(1);
      else if (WRAP)  w_step = MAX_V;
      else            w_step = '0;
    end
    w_next = bus.i_set ? w_load : w_step;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (w_upd) r_out <= w_next;
      r_wrap <= ~bus.i_set & bus.i_en & w_hit;
    end
  end

  assign bus.o_out  = r_out;
  assign bus.o_wrap = r_wrap;
  assign bus.o_tc   = bus.i_en & w_hit;

`ifdef MOD_COUNTER_MATCH_EN
  logic r_match;

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_match <= 1'b0;
    else          r_match <= w_upd & (w_next == bus.i_match_val);
  end

  assign bus.o_match = r_match;
`endif
endmodule

// File: tb/tb_mod_counter_ld.sv
// Three counter configurations driven in lockstep, checked every cycle against an arithmetic model.
module tb_mod_counter_ld;
  logic clk = 1'b0;
  logic rst;
  logic s_set, s_en, s_up;
  logic [4:0] s_init;

  always #5 clk = ~clk;

  mod_counter_ld_if #(.WIDTH(5)) ifa ();
  mod_counter_ld_if #(.WIDTH(4)) ifb ();
  mod_counter_ld_if #(.WIDTH(4)) ifc ();

  assign ifa.i_init = s_init;
  assign ifb.i_init = s_init[3:0];
  assign ifc.i_init = s_init[3:0];
  assign ifa.i_set = s_set;  assign ifb.i_set = s_set;  assign ifc.i_set = s_set;
  assign ifa.i_en  = s_en;   assign ifb.i_en  = s_en;   assign ifc.i_en  = s_en;
  assign ifa.i_up  = s_up;   assign ifb.i_up  = s_up;   assign ifc.i_up  = s_up;
`ifdef MOD_COUNTER_MATCH_EN
  assign ifa.i_match_val = 5'd5;
  assign ifb.i_match_val = 4'd5;
  assign ifc.i_match_val = 4'd5;
`endif

  mod_counter_ld #(.WIDTH(5), .MAX(15), .WRAP(1'b1)) u_a (.i_clk(clk), .i_reset(rst), .bus(ifa.slave));
  mod_counter_ld #(.WIDTH(4), .MAX(9),  .WRAP(1'b1)) u_b (.i_clk(clk), .i_reset(rst), .bus(ifb.slave));
  mod_counter_ld #(.WIDTH(4), .MAX(15), .WRAP(1'b0)) u_c (.i_clk(clk), .i_reset(rst), .bus(ifc.slave));

  int P_W[3]    = '{5, 4, 4};
  int P_MAX[3]  = '{15, 9, 15};
  int P_WRAP[3] = '{1, 1, 0};
  int m_out[3]  = '{0, 0, 0};
  int m_wrap[3] = '{0, 0, 0};
  int m_match[3] = '{0, 0, 0};
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_out(int k);
    case (k)
      0: return 32'(ifa.o_out);
      1: return 32'(ifb.o_out);
      default: return 32'(ifc.o_out);
    endcase
  endfunction

  function automatic logic [31:0] get_wrap(int k);
    case (k)
      0: return 32'(ifa.o_wrap);
      1: return 32'(ifb.o_wrap);
      default: return 32'(ifc.o_wrap);
    endcase
  endfunction

  function automatic logic [31:0] get_tc(int k);
    case (k)
      0: return 32'(ifa.o_tc);
      1: return 32'(ifb.o_tc);
      default: return 32'(ifc.o_tc);
    endcase
  endfunction

`ifdef MOD_COUNTER_MATCH_EN
  function automatic logic [31:0] get_match(int k);
    case (k)
      0: return 32'(ifa.o_match);
      1: return 32'(ifb.o_match);
      default: return 32'(ifc.o_match);
    endcase
  endfunction
`endif

  // Reference: modular arithmetic for wrap mode, clamping for saturate mode.
  function automatic void model_edge(int k);
    int lim = P_MAX[k] + 1;
    int v = int'(s_init) % (1 << P_W[k]);
    int hit = s_up ? (m_out[k] == P_MAX[k]) : (m_out[k] == 0);
    int nxt = m_out[k];
    if (!rst) begin
      m_out[k] = 0; m_wrap[k] = 0; m_match[k] = 0;
      return;
    end
    if (s_set) begin
      nxt = (v > P_MAX[k]) ? P_MAX[k] : v;
      m_wrap[k] = 0;
    end else if (s_en) begin
      if (P_WRAP[k] != 0) nxt = s_up ? (m_out[k] + 1) % lim : (m_out[k] + lim - 1) % lim;
      else                nxt = s_up ? ((m_out[k] < P_MAX[k]) ? m_out[k] + 1 : P_MAX[k])
                                     : ((m_out[k] > 0) ? m_out[k] - 1 : 0);
      m_wrap[k] = hit;
    end else begin
      m_wrap[k] = 0;
    end
    m_match[k] = (s_set || s_en) && (nxt == 5);
    m_out[k] = nxt;
  endfunction

  task automatic cyc(input logic r, input logic st, input int ini, input logic e, input logic u);
    @(negedge clk);
    rst = r; s_set = st; s_init = 5'(ini); s_en = e; s_up = u;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("tc%0d", k), get_tc(k),
          int'(s_en && (s_up ? (m_out[k] == P_MAX[k]) : (m_out[k] == 0))));
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out%0d", k), get_out(k), m_out[k]);
      chk($sformatf("wrap%0d", k), get_wrap(k), m_wrap[k]);
`ifdef MOD_COUNTER_MATCH_EN
      chk($sformatf("match%0d", k), get_match(k), m_match[k]);
`endif
    end
  endtask

  initial begin
    rst = 1'b0; s_set = 1'b0; s_init = '0; s_en = 1'b0; s_up = 1'b1;
    // Reset for two cycles, with set/en active to show reset wins.
    cyc(0, 1, 9, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("reset_out_a", get_out(0), 0);
    // Load and clamp.
    cyc(1, 1, 9, 0, 0);
    chk("load9_a", get_out(0), 9);
    cyc(1, 1, 20, 1, 0);
    chk("clamp20_a", get_out(0), 15);
    // Up wrap on A (MAX=15).
    cyc(1, 1, 14, 0, 1);
    cyc(1, 0, 0, 1, 1);
    chk("upwrap_15_a", get_out(0), 15);
    cyc(1, 0, 0, 1, 1);
    chk("upwrap_0_a", get_out(0), 0);
    chk("upwrap_pulse_a", get_wrap(0), 1);
    // Down wrap on B (MAX=9).
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("dnwrap_9_b", get_out(1), 9);
    chk("dnwrap_pulse_b", get_wrap(1), 1);
    // Saturation on C.
    cyc(1, 1, 13, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 1);
    chk("sat_c", get_out(2), 15);
    chk("sat_wrap_c", get_wrap(2), 1);
    // Load over count, then reset over load, then hold.
    cyc(1, 1, 5, 0, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 3, 1, 1);
    chk("set_over_en_a", get_out(0), 3);
    cyc(0, 1, 6, 1, 1);
    chk("reset_over_set_a", get_out(0), 0);
    cyc(1, 1, 6, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 11, 0, i[0]);
    chk("hold_a", get_out(0), 6);
    // Constrained-random traffic.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
